ac_correlator: RTL and testbench

AC_CORRELATOR -- requirements
Module: ac_correlator

---
 rtl/bt_ac_pkg.sv | 21 ++
 rtl/bt_popcnt64.sv | 23 ++
 rtl/ac_correlator.sv | 123 ++++++++++++
 tb/tb_ac_correlator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bt_ac_pkg.sv
// ---------------------------------------------------------------
// bt_ac_pkg : shared widths and state encoding for ac_correlator
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package bt_ac_pkg;

  localparam int SYNC_W = 64;
  localparam int WCNT_W = 10;
  localparam int MCNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SEARCH = 2'd2
  } ac_state_e;

endpackage

`default_nettype wire

// File: rtl/bt_popcnt64.sv
// ---------------------------------------------------------------
// bt_popcnt64 : combinational population count of a 64-bit word
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bt_popcnt64
  import bt_ac_pkg::*;
(
  input  logic [SYNC_W-1:0] data_i,
  output logic [MCNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      cnt_o = cnt_o + {{(MCNT_W-1){1'b0}}, data_i[i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/ac_correlator.sv
// ---------------------------------------------------------------
// ac_correlator : sliding 64-bit access-code correlator with window
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module ac_correlator
  import bt_ac_pkg::*;
(
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic [SYNC_W-1:0] regi_syncword,
  input  logic [5:0]        regi_correthreshold,
  input  logic [WCNT_W-1:0] regi_winlen,
  input  logic              search_start_p,
  input  logic              search_abort_p,
  input  logic              rxbit,
  input  logic              rxbit_valid_p,
  output logic              sync_p,
  output logic              timeout_p,
  output logic              busy,
  output logic [WCNT_W-1:0] sync_bitcnt,
  output logic [MCNT_W-1:0] match_cnt
);

  ac_state_e         state_q;
  logic [SYNC_W-1:0] shreg_q;
  logic [MCNT_W-1:0] fill_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;
  logic              eval_q;
  logic              wend_q;
  logic [MCNT_W-1:0] match_q;
  logic [WCNT_W-1:0] bitcnt_q;
  logic              sync_q;
  logic              tout_q;

  logic              w_strobe;
  logic              w_full;
  logic              w_wend;
  logic              w_hit;
  logic [MCNT_W-1:0] w_diff;
  logic [MCNT_W-1:0] w_match;

  bt_popcnt64 u_popcnt (
    .data_i (shreg_q ^ regi_syncword),
    .cnt_o  (w_diff)
  );

  assign w_match  = MCNT_W'(SYNC_W) - w_diff;
  assign w_hit    = (w_match >= {1'b0, regi_correthreshold});
  assign w_strobe = rxbit_valid_p && (state_q != ST_IDLE);
  assign wcnt_d   = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
  // The strobe that completes the fill already gets evaluated.
  assign w_full   = (state_q == ST_SEARCH) || (fill_q == MCNT_W'(SYNC_W - 1));
  assign w_wend   = (regi_winlen != '0) && (wcnt_d == regi_winlen);

  always_ff @(posedge clk_6M or posedge rstz) begin
    if (rstz) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      fill_q   <= '0;
      wcnt_q   <= '0;
      eval_q   <= 1'b0;
      wend_q   <= 1'b0;
      match_q  <= '0;
      bitcnt_q <= '0;
      sync_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      sync_q <= 1'b0;
      tout_q <= 1'b0;
      if (search_abort_p) begin
        state_q <= ST_IDLE;
        eval_q  <= 1'b0;
        wend_q  <= 1'b0;
      end else if (search_start_p) begin
        state_q  <= ST_FILL;
        shreg_q  <= '0;
        fill_q   <= '0;
        wcnt_q   <= '0;
        eval_q   <= 1'b0;
        wend_q   <= 1'b0;
        bitcnt_q <= '0;
      end else if (eval_q || wend_q) begin
        // Resolve the previous strobe; a hit overrides a coincident window end.
        eval_q <= 1'b0;
        wend_q <= 1'b0;
        if (eval_q) begin
          match_q <= w_match;
        end
        if (eval_q && w_hit) begin
          sync_q   <= 1'b1;
          bitcnt_q <= wcnt_q;
          state_q  <= ST_IDLE;
        end else if (wend_q) begin
          tout_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
      end else if (w_strobe) begin
        shreg_q <= {rxbit, shreg_q[SYNC_W-1:1]};
        wcnt_q  <= wcnt_d;
        eval_q  <= w_full;
        wend_q  <= w_wend;
        if (state_q == ST_FILL) begin
          fill_q <= fill_q + 1'b1;
          if (w_full) begin
            state_q <= ST_SEARCH;
          end
        end
      end
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign sync_p      = sync_q;
  assign timeout_p   = tout_q;
  assign sync_bitcnt = bitcnt_q;
  assign match_cnt   = match_q;

endmodule

`default_nettype wire

// File: tb/tb_ac_correlator.sv
// ---------------------------------------------------------------
// tb_ac_correlator : randomized directed bench with reference model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_ac_correlator;

  logic        clk_6M = 1'b0;
  logic        rstz   = 1'b1;
  logic [63:0] regi_syncword = '0;
  logic [5:0]  regi_correthreshold = '0;
  logic [9:0]  regi_winlen = '0;
  logic        search_start_p = 1'b0;
  logic        search_abort_p = 1'b0;
  logic        rxbit = 1'b0;
  logic        rxbit_valid_p = 1'b0;
  logic        sync_p;
  logic        timeout_p;
  logic        busy;
  logic [9:0]  sync_bitcnt;
  logic [6:0]  match_cnt;

  ac_correlator dut (
    .clk_6M              (clk_6M),
    .rstz                (rstz),
    .regi_syncword       (regi_syncword),
    .regi_correthreshold (regi_correthreshold),
    .regi_winlen         (regi_winlen),
    .search_start_p      (search_start_p),
    .search_abort_p      (search_abort_p),
    .rxbit               (rxbit),
    .rxbit_valid_p       (rxbit_valid_p),
    .sync_p              (sync_p),
    .timeout_p           (timeout_p),
    .busy                (busy),
    .sync_bitcnt         (sync_bitcnt),
    .match_cnt           (match_cnt)
  );

  always #5 clk_6M = ~clk_6M;

  int  checks = 0;
  int  passed = 0;
  int  fails  = 0;
  int  n_sync = 0;
  int  n_tout = 0;
  int  n_both = 0;
  time t_sync = 0;
  time t_tout = 0;

  bit  bits [1:400];
  time st_t [1:400];

  localparam logic [63:0] SW = 64'h7e7041e34000000d;

  always @(negedge clk_6M) begin
    if (sync_p) begin n_sync++; t_sync = $time; end
    if (timeout_p) begin n_tout++; t_tout = $time; end
    if (sync_p && timeout_p) n_both++;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input bit b, input int idx);
    rxbit = b;
    rxbit_valid_p = 1'b1;
    @(posedge clk_6M);
    st_t[idx] = $time;
    #1 rxbit_valid_p = 1'b0;
    repeat (5) @(posedge clk_6M);
    #1;
  endtask

  task automatic pulse(input bit is_abort);
    if (is_abort) search_abort_p = 1'b1; else search_start_p = 1'b1;
    @(posedge clk_6M);
    #1 search_abort_p = 1'b0;
    search_start_p = 1'b0;
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) bits[i] = 1'($urandom);
  endtask

  task automatic place_word(input int pos, input logic [63:0] w, input int nflip);
    int off;
    logic [63:0] v;
    v = w;
    off = $urandom_range(0, 63);
    for (int k = 0; k < nflip; k++) v[(off + k * 13) % 64] = ~v[(off + k * 13) % 64];
    for (int i = 0; i < 64; i++) bits[pos + i] = v[i];
  endtask

  // Reference: slide over the received stream, oldest-first alignment with the word.
  task automatic run_search(input string tag, input int n, input int winlen,
                            input int thr, input logic [63:0] sw);
    int det, tout, m, last_m, s0, t0;
    det = 0; tout = 0; last_m = -1;
    for (int k = 1; k <= n; k++) begin
      if (k >= 64) begin
        m = 0;
        for (int i = 0; i < 64; i++) if (bits[k - 63 + i] == sw[i]) m++;
        last_m = m;
        if (m >= thr) begin det = k; break; end
      end
      if (winlen != 0 && k == winlen) begin tout = k; break; end
    end
    regi_syncword = sw;
    regi_correthreshold = 6'(thr);
    regi_winlen = 10'(winlen);
    s0 = n_sync; t0 = n_tout;
    pulse(1'b0);
    for (int k = 1; k <= n; k++) send_bit(bits[k], k);
    repeat (3) @(posedge clk_6M);
    #1;
    check({tag, " sync count"}, n_sync - s0, (det != 0) ? 1 : 0);
    check({tag, " timeout count"}, n_tout - t0, (tout != 0) ? 1 : 0);
    if (det != 0) begin
      check({tag, " sync time"}, t_sync, st_t[det] + 15);
      check({tag, " sync_bitcnt"}, sync_bitcnt, det);
    end
    if (tout != 0) check({tag, " timeout time"}, t_tout, st_t[tout] + 15);
    if (last_m >= 0) check({tag, " match_cnt"}, match_cnt, last_m);
    if (det != 0 || tout != 0) check({tag, " busy after end"}, busy, 0);
    check({tag, " no overlap"}, n_both, 0);
  endtask

  initial begin
    int s0, t0;
    repeat (2) @(posedge clk_6M);
    #1;
    check("reset sync_p", sync_p, 0);
    check("reset timeout_p", timeout_p, 0);
    check("reset busy", busy, 0);
    check("reset sync_bitcnt", sync_bitcnt, 0);
    check("reset match_cnt", match_cnt, 0);
    rstz = 1'b0;
    @(posedge clk_6M);
    #1;

    fill_random(1, 100); place_word(21, SW, 0);
    run_search("exact", 100, 200, 60, SW);
    check("exact bitcnt=84", sync_bitcnt, 84);
    check("exact match=64", match_cnt, 64);

    fill_random(1, 100); place_word(21, SW, 4);
    run_search("flip4", 100, 200, 60, SW);
    check("flip4 match=60", match_cnt, 60);

    fill_random(1, 200); place_word(21, SW, 5);
    run_search("flip5", 200, 200, 60, SW);

    fill_random(1, 45);
    run_search("win40", 45, 40, 60, SW);

    // Abort partway through, then a fresh search carrying the word immediately.
    s0 = n_sync; t0 = n_tout;
    pulse(1'b0);
    fill_random(1, 30);
    for (int k = 1; k <= 30; k++) send_bit(bits[k], k);
    check("abort busy before", busy, 1);
    pulse(1'b1);
    check("abort busy after", busy, 0);
    repeat (10) @(posedge clk_6M);
    #1;
    check("abort no pulses", (n_sync - s0) + (n_tout - t0), 0);
    place_word(1, SW, 0);
    run_search("restart", 64, 200, 60, SW);
    check("restart bitcnt=64", sync_bitcnt, 64);

    place_word(1, SW, 0);
    run_search("edge64", 64, 64, 60, SW);

    // Restart while busy discards the partial search.
    pulse(1'b0);
    fill_random(1, 10);
    for (int k = 1; k <= 10; k++) send_bit(bits[k], k);
    fill_random(1, 94); place_word(31, SW, 2);
    run_search("busy restart", 94, 0, $urandom_range(56, 64), SW);

    for (int r = 0; r < 3; r++) begin
      fill_random(1, 150);
      run_search("random", 150, $urandom_range(64, 150), $urandom_range(38, 44),
                 {$urandom, $urandom});
    end

    // Asynchronous reset in the middle of the fill.
    s0 = n_sync; t0 = n_tout;
    fill_random(1, 120); place_word(21, SW, 0);
    regi_winlen = 10'd30;
    pulse(1'b0);
    for (int k = 1; k <= 20; k++) send_bit(bits[k], k);
    rstz = 1'b1;
    #1;
    check("rst sync_p", sync_p, 0);
    check("rst timeout_p", timeout_p, 0);
    check("rst busy", busy, 0);
    check("rst sync_bitcnt", sync_bitcnt, 0);
    check("rst match_cnt", match_cnt, 0);
    @(posedge clk_6M);
    #1 rstz = 1'b0;
    for (int k = 21; k <= 90; k++) send_bit(bits[k], k);
    check("rst no later pulses", (n_sync - s0) + (n_tout - t0), 0);
    check("rst stays idle", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
